// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals of alu_arbiter. The master side holds the requesters, the ALU and the response consumer.
// The slave side is the arbiter; no handshake latency is added here.
interface alu_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_data;
  logic             resp_carry;
  logic             resp_zero;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_res, alu_cout,
    input  resp_valid, resp_id, resp_data, resp_carry, resp_zero,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_res, alu_cout,
    output resp_valid, resp_id, resp_data, resp_carry, resp_zero,
    input  resp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; grant at T gives resp_valid at T+2, next grant at T+3.
// Requesters stall (ready low) outside IDLE; resp_ready low holds RESP. Optional flags via ALU_ARB_FLAGS_EN.
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last;
  logic   id;
  logic   gnt0;
  logic   gnt1;

  // On a tie, the requester not served last wins.
  always_comb begin
    gnt0 = bus.req0_valid && (!bus.req1_valid || last);
    gnt1 = bus.req1_valid && (!bus.req0_valid || !last);
  end

  assign bus.req0_ready = (state == IDLE) && !rst && gnt0;
  assign bus.req1_ready = (state == IDLE) && !rst && gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last           <= 1'b1;
      id             <= 1'b0;
      bus.alu_op     <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= 1'b0;
      bus.resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0) begin
            bus.alu_op <= bus.req0_op;
            bus.alu_a  <= bus.req0_a;
            bus.alu_b  <= bus.req0_b;
            id         <= 1'b0;
            state      <= EXEC;
          end else if (gnt1) begin
            bus.alu_op <= bus.req1_op;
            bus.alu_a  <= bus.req1_a;
            bus.alu_b  <= bus.req1_b;
            id         <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          bus.resp_data  <= bus.alu_res;
          bus.resp_id    <= id;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            last           <= bus.resp_id;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.resp_carry <= 1'b0;
      bus.resp_zero  <= 1'b0;
    end else if (state == EXEC) begin
      bus.resp_carry <= bus.alu_cout;
      bus.resp_zero  <= (bus.alu_res == '0);
    end
  end
`else
  logic unused_cout;

  assign unused_cout    = bus.alu_cout;
  assign bus.resp_carry = 1'b0;
  assign bus.resp_zero  = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational ALU between two requesters. Each requester presents a 3-bit opcode and two operands over a valid/ready handshake. The block registers the winning command and drives it to the ALU, where the opcode is decoded into carry-in, operation-select and complement controls. It then captures the result and carry-out and returns them over a response handshake tagged with the requester ID.

## Interface
- WIDTH, 4, operand/result width in bits
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- req0_valid  input  1  requester 0 command valid
- req0_ready  output  1  requester 0 command accepted this cycle
- req0_op  input  3  requester 0 ALU opcode
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- alu_op  output  3  opcode to ALU (registered)
- alu_a  output  WIDTH  operand A to ALU (registered)
- alu_b  output  WIDTH  operand B to ALU (registered)
- alu_res  input  WIDTH  ALU result (combinational from alu_op/a/b)
- alu_cout  input  1  ALU carry-out
- resp_valid  output  1  response valid
- resp_ready  input  1  consumer accepts response
- resp_id  output  1  requester that issued the response (0/1)
- resp_data  output  WIDTH  captured ALU result
- resp_carry  output  1  captured carry-out
- resp_zero  output  1  1 when captured result == 0

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and asserted only for the granted requester, and only in IDLE.
  - Grant: if only one reqN_valid is high, that requester wins. If both are high, the requester that was not granted last wins (pointer `last`).
  - On grant: latch op/a/b into alu_op/alu_a/alu_b, latch the ID, and go to EXEC.
  - No valid: stay in IDLE, with both ready signals at 0.
- EXEC: the ALU inputs are stable for the whole cycle. At the clock edge, capture alu_res into resp_data, alu_cout into resp_carry, and (alu_res == 0) into resp_zero. Go to RESP.
- RESP:
  - resp_valid=1; resp_id/data/carry/zero are held stable.
  - When resp_ready=1: update `last` to resp_id and go to IDLE.
  - When resp_ready=0: remain in RESP, with all response outputs unchanged.
- alu_op/a/b hold the last issued command in RESP and IDLE until the next grant.
- Requesters must hold valid and payload stable until ready. A requester that drops valid before it is granted loses nothing.
- Opcodes are passed through unchecked; all 8 values are legal.
- Widths: resp_data is WIDTH bits, with no extension. The carry comes only from alu_cout.

## Timing
- Reset values:
  - State IDLE; `last`=1, so req0 wins the first tie.
  - resp_valid=0, resp_id=0, resp_data=0, resp_carry=0, resp_zero=0.
  - alu_op=0, alu_a=0, alu_b=0; req0_ready=req1_ready=0.
- Latency: handshake accepted at cycle T gives resp_valid=1 at T+2.
- Throughput: with resp_ready tied high, one command every 3 cycles; the next grant can occur at T+3.
- Simultaneous valid in IDLE: exactly one ready is high. The other requester waits at least 3 cycles.
- Reset asserted in any state: the next cycle is IDLE with reset values. Any in-flight command and response are discarded, with no resp_valid pulse.
- resp_ready high while not in RESP: ignored.

## Configuration
- ALU_ARB_FLAGS_EN:
  - Defined: resp_carry and resp_zero are captured in EXEC as described.
  - Undefined: the flag registers are not built, and resp_carry and resp_zero are tied to 0. alu_cout is unused.
  - All other behaviour is identical in both builds.

## Test plan
- Single request: req0 op=3'b001, a=4'h5, b=4'h3, with an ALU model returning res=4'h8, cout=0. Expect req0_ready in the accept cycle and resp_valid 2 cycles later with id=0, data=4'h8, carry=0, zero=0.
- Tie after reset: req0 and req1 both valid in the same cycle. Expect req0 granted first and req1 granted 3 cycles later. A third back-to-back tie must grant req1 over req0 only if req0 was last; check the alternation 0,1,0,1 over 4 commands.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP. Expect resp_valid and all response fields stable, and no reqN_ready pulse. After release, return to IDLE the next cycle.
- Zero/carry: ALU model returns res=4'h0, cout=1. With ALU_ARB_FLAGS_EN, expect resp_zero=1, resp_carry=1. Without it, expect both 0.
- Reset mid-operation: assert rst in EXEC, then separately in RESP. Expect resp_valid=0 on the next cycle, all outputs at reset values, and the first tie after reset granted to req0.
